// File: rtl/neuron_sched_pkg.sv
// Shared types and constants for the neuron pool update scheduler.
package neuron_sched_pkg;

  localparam int unsigned NN_DEF         = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  // Phase field of neuronCounter
  localparam logic [1:0] PH_READ    = 2'd0;
  localparam logic [1:0] PH_COMPUTE = 2'd1;
  localparam logic [1:0] PH_WRITE   = 2'd2;
  localparam logic [1:0] PH_SPIKE   = 2'd3;

  // Low two bits of each active state double as the phase field driven to the pool
  typedef enum logic [2:0] {
    ST_PH0  = {1'b0, PH_READ},
    ST_PH1  = {1'b0, PH_COMPUTE},
    ST_PH2  = {1'b0, PH_WRITE},
    ST_PH3  = {1'b0, PH_SPIKE},
    ST_IDLE = 3'b100
  } sched_state_e;

endpackage

// File: rtl/spk_fifo.sv
// Spike-ID FIFO: show-ahead head, push accepted when full if a pop happens in the same cycle.
module spk_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic         rawclk,
  input  logic         reset_sim_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         wr_en_c;
  logic         rd_en_c;

  // Status flags from the extra pointer wrap bit, plus head read-out
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    rd_en_c = pop && !empty;
    wr_en_c = push && (!full || rd_en_c);
    head    = mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en_c) wr_q <= wr_q + (AW+1)'(1);
      if (rd_en_c) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are only observed while non-empty, so no reset
  always_ff @(posedge rawclk) begin
    if (wr_en_c) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/neuron_sched.sv
// Neuron pool update scheduler: step-timer divider, 4-phase sweep FSM, spike-ID output.
// Optional spike buffering is enabled by defining NEURON_SCHED_SPKFIFO_EN.
module neuron_sched
  import neuron_sched_pkg::*;
#(
  parameter int unsigned NN         = NN_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          rawclk,
  input  logic          reset_sim_n,
  input  logic          en,
  input  logic [31:0]   half_cnt,
  input  logic          upd_ack,
  input  logic          spike_in,
  input  logic          spk_ready,
  output logic [NN+2:0] neuronCounter,
  output logic          upd_req,
  output logic          busy,
  output logic          step_done,
  output logic          spk_valid,
  output logic          overrun,
  output logic [15:0]   spkid,
  output logic [15:0]   drop_cnt
);

  localparam int unsigned IW = NN + 1;
  localparam logic [IW-1:0] IDX_MAX = '1;

  logic [31:0]   div_q;
  logic          tick_c;
  sched_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          push_c;

  // >= rather than == so a lowered half_cnt cannot strand the counter above it
  assign tick_c = en && (div_q >= half_cnt);

  // Step-timer divider: holds at 0 while disabled
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n)         div_q <= '0;
    else if (!en || tick_c)   div_q <= '0;
    else                      div_q <= div_q + 32'd1;
  end

  // FSM state and neuron index registers
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and decoded outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    upd_req       = 1'b0;
    busy          = 1'b1;
    step_done     = 1'b0;
    push_c        = 1'b0;
    neuronCounter = {idx_q, state_q[1:0]};
    unique case (state_q)
      ST_IDLE: begin
        busy          = 1'b0;
        neuronCounter = '0;
        idx_d         = '0;
        if (tick_c) state_d = ST_PH0;
      end
      ST_PH0: state_d = ST_PH1;
      ST_PH1: begin
        upd_req = 1'b1;
        if (upd_ack) state_d = ST_PH2;
      end
      ST_PH2: state_d = ST_PH3;
      ST_PH3: begin
        push_c = spike_in;
        if (idx_q == IDX_MAX) begin
          step_done = 1'b1;
          idx_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_PH0;
        end
      end
      default: begin
        busy          = 1'b0;
        neuronCounter = '0;
        idx_d         = '0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // Sticky flag: a tick arrived while a sweep was still running
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n)                      overrun <= 1'b0;
    else if (tick_c && state_q != ST_IDLE) overrun <= 1'b1;
  end

`ifdef NEURON_SCHED_SPKFIFO_EN
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_c;
  logic [IW-1:0] fifo_head;
  logic [15:0]   drop_q;

  assign pop_c = !fifo_empty && spk_ready;

  spk_fifo #(
    .W     (IW),
    .DEPTH (FIFO_DEPTH)
  ) u_spk_fifo (
    .rawclk      (rawclk),
    .reset_sim_n (reset_sim_n),
    .push        (push_c),
    .push_data   (idx_q),
    .pop         (pop_c),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head)
  );

  // Saturating count of spikes lost to a full FIFO
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n)
      drop_q <= '0;
    else if (push_c && fifo_full && !pop_c && drop_q != 16'hFFFF)
      drop_q <= drop_q + 16'd1;
  end

  assign spk_valid = !fifo_empty;
  assign spkid     = 16'(fifo_head);
  assign drop_cnt  = drop_q;
`else
  logic unused_ok;

  // Unbuffered: spike is visible only during its PH3 cycle, no backpressure
  assign spk_valid = push_c;
  assign spkid     = 16'(idx_q);
  assign drop_cnt  = '0;
  assign unused_ok = spk_ready ^ (FIFO_DEPTH == 0);
`endif

endmodule

// File: tb/tb_neuron_sched.sv
// Self-checking bench for neuron_sched: timer/overrun, stalled sweeps, spike IDs, FIFO overflow, reset.
module tb_neuron_sched;

`ifdef NEURON_SCHED_SPKFIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic rawclk = 1'b0;
  always #5 rawclk = ~rawclk;

  logic reset_sim_n;

  // Instance A: NN=0 (2 neurons), upd_ack tied high, no spikes
  logic        en_a;
  logic [31:0] hc_a;
  logic [2:0]  unused_a_nc;
  logic        unused_a_ur;
  logic        busy_a;
  logic        sd_a_o;
  logic        unused_a_sv;
  logic        ovr_a;
  logic [15:0] unused_a_spkid;
  logic [15:0] unused_a_drop;

  neuron_sched #(.NN(0)) dut_a (
    .rawclk        (rawclk),
    .reset_sim_n   (reset_sim_n),
    .en            (en_a),
    .half_cnt      (hc_a),
    .upd_ack       (1'b1),
    .spike_in      (1'b0),
    .spk_ready     (1'b1),
    .neuronCounter (unused_a_nc),
    .upd_req       (unused_a_ur),
    .busy          (busy_a),
    .step_done     (sd_a_o),
    .spk_valid     (unused_a_sv),
    .overrun       (ovr_a),
    .spkid         (unused_a_spkid),
    .drop_cnt      (unused_a_drop)
  );

  // Instance B: NN=1 (4 neurons), 4-entry FIFO
  logic        en_b;
  logic [31:0] hc_b;
  logic        ack_b;
  logic        spike_b;
  logic        rdy_b;
  logic [3:0]  nc_b;
  logic        ur_b;
  logic        busy_b;
  logic        sd_b;
  logic        sv_b;
  logic        ovr_b;
  logic [15:0] spkid_b;
  logic [15:0] drop_b;

  neuron_sched #(.NN(1), .FIFO_DEPTH(4)) dut_b (
    .rawclk        (rawclk),
    .reset_sim_n   (reset_sim_n),
    .en            (en_b),
    .half_cnt      (hc_b),
    .upd_ack       (ack_b),
    .spike_in      (spike_b),
    .spk_ready     (rdy_b),
    .neuronCounter (nc_b),
    .upd_req       (ur_b),
    .busy          (busy_b),
    .step_done     (sd_b),
    .spk_valid     (sv_b),
    .overrun       (ovr_b),
    .spkid         (spkid_b),
    .drop_cnt      (drop_b)
  );

  // Datapath model: spike flag from a per-neuron mask, ack after a programmable stall
  logic [3:0] mask_b  = 4'b0000;
  logic [3:0] ack_dly = 4'd0;
  logic [3:0] ack_cnt = 4'd0;

  always @(posedge rawclk) ack_cnt <= ur_b ? ack_cnt + 4'd1 : 4'd0;

  always_comb begin
    spike_b = mask_b[nc_b[3:2]] && (nc_b[1:0] == 2'd3) && busy_b;
    ack_b   = (ack_dly == 4'd0) ? 1'b1 : (ur_b && ack_cnt == ack_dly);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // Monitor state
  int cyc_n = 0;
  bit busy_a_p = 1'b0;
  int rise_n_a = 0, fall_n_a = 0, run_a = 0, sd_a = 0;
  int rise_a[2];
  int runs_a[2];
  logic ovr_rise0 = 1'b1;
  bit busy_b_p = 1'b0;
  int run_b = 0, last_run_b = 0, busy_cyc_b = 0;
  int ur_cnt = 0, ur_run = 0, ur_last = 0;
  int sd_cnt = 0, sv_cnt = 0, sb_extra = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample both DUTs mid-cycle; scoreboard pops on every accepted spike ID
  task automatic cyc();
    @(negedge rawclk);
    cyc_n++;
    if (busy_a && !busy_a_p) begin
      if (rise_n_a < 2) rise_a[rise_n_a] = cyc_n;
      if (rise_n_a == 0) ovr_rise0 = ovr_a;
      rise_n_a++;
      run_a = 0;
    end
    if (busy_a) run_a++;
    if (!busy_a && busy_a_p) begin
      if (fall_n_a < 2) runs_a[fall_n_a] = run_a;
      fall_n_a++;
    end
    busy_a_p = busy_a;
    if (sd_a_o) sd_a++;

    if (busy_b) begin
      busy_cyc_b++;
      run_b++;
    end else if (busy_b_p) begin
      last_run_b = run_b;
      run_b = 0;
    end
    busy_b_p = busy_b;
    if (ur_b) begin
      ur_cnt++;
      ur_run++;
    end else if (ur_run != 0) begin
      ur_last = ur_run;
      ur_run = 0;
    end
    if (sd_b) sd_cnt++;
    if (sv_b) sv_cnt++;
    if (sv_b && (rdy_b || !FIFO_EN)) begin
      if (exp_q.size() == 0) sb_extra++;
      else chk_eq("spkid", 32'(spkid_b), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic run_sweep_b(input string tag);
    int n = 0;
    en_b = 1'b1;
    while (!busy_b && n < 300) begin cyc(); n++; end
    en_b = 1'b0;
    while (busy_b && n < 600) begin cyc(); n++; end
    chk_eq({tag, "_timeout"}, 32'(n >= 600 || !busy_b_p && last_run_b == 0), 32'd0);
  endtask

  initial begin
    int n;
    int s_ur, s_sd, s_sv, s_busy;
    reset_sim_n = 1'b0;
    en_a = 1'b0; hc_a = 32'd3;
    en_b = 1'b0; hc_b = 32'd9; rdy_b = 1'b0;
    repeat (3) cyc();
    reset_sim_n = 1'b1;
    cyc();

    // Reset state
    chk_eq("rst_busy", 32'(busy_b), 32'd0);
    chk_eq("rst_nc", 32'(nc_b), 32'd0);
    chk_eq("rst_valid", 32'(sv_b), 32'd0);
    chk_eq("rst_drop", 32'(drop_b), 32'd0);
    chk_eq("rst_ovr", 32'(ovr_b), 32'd0);
    chk_eq("rst_sd", 32'(sd_b), 32'd0);
    chk_eq("rst_ureq", 32'(ur_b), 32'd0);

    // Timer vs sweep length on 2 neurons: ticks every 4, sweeps of 8, overrun from tick 2
    en_a = 1'b1;
    n = 0;
    while (sd_a < 2 && n < 100) begin cyc(); n++; end
    en_a = 1'b0;
    while (busy_a && n < 150) begin cyc(); n++; end
    chk_eq("t1_sweeps", 32'(sd_a), 32'd2);
    chk_eq("t1_gap", 32'(rise_a[1] - rise_a[0]), 32'd12);
    chk_eq("t1_len0", 32'(runs_a[0]), 32'd8);
    chk_eq("t1_len1", 32'(runs_a[1]), 32'd8);
    chk_eq("t1_ovr_first", 32'(ovr_rise0), 32'd0);
    chk_eq("t1_ovr_sticky", 32'(ovr_a), 32'd1);

    // Stalled datapath: 3-cycle ack delay per neuron
    hc_b = 32'd99; ack_dly = 4'd3;
    s_ur = ur_cnt; s_sd = sd_cnt;
    run_sweep_b("t2");
    chk_eq("t2_len", 32'(last_run_b), 32'd28);
    chk_eq("t2_ureq", 32'(ur_cnt - s_ur), 32'd16);
    chk_eq("t2_ph1", 32'(ur_last), 32'd4);
    chk_eq("t2_sd", 32'(sd_cnt - s_sd), 32'd1);
    chk_eq("t2_ovr", 32'(ovr_b), 32'd0);

    // Spikes at 1 and 3, consumer always ready
    hc_b = 32'd9; ack_dly = 4'd0; rdy_b = 1'b1; mask_b = 4'b1010;
    exp_q.push_back(1); exp_q.push_back(3);
    s_sv = sv_cnt;
    run_sweep_b("t3");
    repeat (3) cyc();
    chk_eq("t3_len", 32'(last_run_b), 32'd16);
    chk_eq("t3_valid_cyc", 32'(sv_cnt - s_sv), 32'd2);
    chk_eq("t3_left", 32'(exp_q.size()), 32'd0);

    if (FIFO_EN) begin
      // Six spikes into a 4-deep FIFO with no consumer, then drain
      rdy_b = 1'b0; mask_b = 4'b1111;
      for (int i = 0; i < 4; i++) exp_q.push_back(i);
      run_sweep_b("t4a");
      mask_b = 4'b0011;
      run_sweep_b("t4b");
      mask_b = 4'b0000;
      chk_eq("t4_drop", 32'(drop_b), 32'd2);
      chk_eq("t4_valid", 32'(sv_b), 32'd1);
      chk_eq("t4_head", 32'(spkid_b), 32'd0);
      repeat (3) cyc();
      chk_eq("t4_head_hold", 32'(spkid_b), 32'd0);
      s_sv = sv_cnt;
      rdy_b = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin cyc(); n++; end
      cyc();
      chk_eq("t4_left", 32'(exp_q.size()), 32'd0);
      chk_eq("t4_drain_cyc", 32'(sv_cnt - s_sv), 32'd4);
      chk_eq("t4_empty", 32'(sv_b), 32'd0);
    end else begin
      // Unbuffered: one-cycle spike ID at index 2, ready ignored
      rdy_b = 1'b0; mask_b = 4'b0100;
      exp_q.push_back(2);
      s_sv = sv_cnt;
      run_sweep_b("t4");
      mask_b = 4'b0000;
      chk_eq("t4_valid_cyc", 32'(sv_cnt - s_sv), 32'd1);
      chk_eq("t4_left", 32'(exp_q.size()), 32'd0);
      chk_eq("t4_drop", 32'(drop_b), 32'd0);
    end

    // Reset during PH1 of index 2 with a queued (unconsumed) spike ID
    rdy_b = 1'b0; ack_dly = 4'd3;
    mask_b = FIFO_EN ? 4'b0001 : 4'b0000;
    s_sd = sd_cnt;
    en_b = 1'b1;
    n = 0;
    while (!busy_b && n < 100) begin cyc(); n++; end
    en_b = 1'b0;
    while (nc_b != 4'b1001 && n < 200) begin cyc(); n++; end
    chk_eq("t5_reach_ph1", 32'(nc_b), 32'b1001);
    reset_sim_n = 1'b0;
    #1;
    chk_eq("t5_busy", 32'(busy_b), 32'd0);
    chk_eq("t5_nc", 32'(nc_b), 32'd0);
    chk_eq("t5_valid", 32'(sv_b), 32'd0);
    chk_eq("t5_ureq", 32'(ur_b), 32'd0);
    cyc();
    reset_sim_n = 1'b1;
    mask_b = 4'b0000; ack_dly = 4'd0; rdy_b = 1'b1;
    repeat (10) cyc();
    chk_eq("t5_no_sd", 32'(sd_cnt - s_sd), 32'd0);
    chk_eq("t5_idle", 32'(busy_b), 32'd0);
    chk_eq("t5_flushed", 32'(sv_b), 32'd0);

    // Disabled timer never starts a sweep
    hc_b = 32'd2; en_b = 1'b0;
    s_busy = busy_cyc_b;
    repeat (20) cyc();
    chk_eq("t6_en0", 32'(busy_cyc_b - s_busy), 32'd0);

    chk_eq("sb_extra", 32'(sb_extra), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_sched.md
NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 The block SHALL have parameter NN, default 8, meaning pool size NUM_NEURON = 2^(NN+1).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning spike-ID FIFO entries (power of two).
REQ-003 The block SHALL have port rawclk, input, 1, meaning the single clock; all logic on posedge.
REQ-004 The block SHALL have port reset_sim_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1, meaning step-timer enable.
REQ-006 The block SHALL have port half_cnt, input, 32, meaning step period minus one, in rawclk cycles.
REQ-007 The block SHALL have port upd_ack, input, 1, meaning the shared neuron datapath has finished the current update.
REQ-008 The block SHALL have port spike_in, input, 1, meaning the datapath spike flag for the current neuron.
REQ-009 The block SHALL have port spk_ready, input, 1, meaning the downstream consumer accepts spkid.
REQ-010 The block SHALL have port neuronCounter, output, NN+3, meaning {neuronIndex[NN:0], state[1:0]} driven to the pool.
REQ-011 The block SHALL have ports upd_req, busy, step_done, spk_valid and overrun, each output, 1, meaning: update request, sweep in progress, end-of-sweep pulse, spike ID available, and sticky missed-tick flag.
REQ-012 The block SHALL have port spkid, output, 16, meaning the zero-extended neuron index of a spiking neuron.
REQ-013 The block SHALL have port drop_cnt, output, 16, meaning the saturating count of spikes lost to a full FIFO.

Function
REQ-014 The divider SHALL count 0..half_cnt and, on the cycle it equals half_cnt, emit a one-cycle tick and return to 0; the tick period SHALL be half_cnt+1 cycles.
REQ-015 With en=0 the divider SHALL hold at 0 and emit no tick; a sweep already in progress SHALL complete.
REQ-016 The FSM states SHALL be IDLE, PH0 (read), PH1 (compute), PH2 (write) and PH3 (spike); state[1:0] SHALL encode PH0..PH3 as 0..3.
REQ-017 IDLE SHALL go to PH0 with index 0 on a tick; a tick arriving outside IDLE SHALL be dropped and SHALL set overrun.
REQ-018 PH0->PH1, PH2->PH3: each SHALL take 1 cycle unconditionally.
REQ-019 In PH1, upd_req SHALL be 1 combinationally and the FSM SHALL stay in PH1 until the cycle upd_ack=1; upd_ack outside PH1 SHALL be ignored.
REQ-020 In PH3 with index < NUM_NEURON-1, the FSM SHALL go to PH0 with index+1; with index = NUM_NEURON-1 it SHALL go to IDLE and pulse step_done for that PH3 cycle.
REQ-021 With upd_ack held at 1, a sweep SHALL last exactly 4*NUM_NEURON cycles; busy SHALL be 1 in every non-IDLE state.
REQ-022 In IDLE, neuronCounter SHALL be 0.
REQ-023 In PH3, spike_in=1 SHALL push the index into the FIFO; when the FIFO is full the push SHALL be dropped and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-024 When the FIFO is full, a push and a pop (spk_valid&spk_ready) in the same cycle SHALL both succeed.
REQ-025 spk_valid SHALL equal FIFO not-empty, spkid SHALL present the head entry, and the head SHALL be stable while spk_valid=1 and spk_ready=0.

Reset
REQ-026 On reset_sim_n=0, the block SHALL asynchronously clear the FSM to IDLE and clear the divider, FIFO pointers, overrun, drop_cnt and all outputs to 0.
REQ-027 Reset mid-sweep SHALL abandon the sweep with no step_done and SHALL discard queued spike IDs.

Configuration
REQ-028 With macro NEURON_SCHED_SPKFIFO_EN defined, the block SHALL provide spike buffering per REQ-023..025.
REQ-029 Without NEURON_SCHED_SPKFIFO_EN, spk_valid SHALL equal the PH3 spike_in, spkid SHALL be the current index, spk_ready SHALL be ignored, and drop_cnt SHALL be tied to 0.

Structure
REQ-030 Package neuron_sched_pkg SHALL hold the FSM state enum, the default NN and FIFO_DEPTH values, and the phase encoding constants.
REQ-031 The FIFO SHALL be a separate sub-module named spk_fifo, instantiated only under NEURON_SCHED_SPKFIFO_EN.

Verification
REQ-032 With NN=0 (NUM_NEURON=2), half_cnt=3, en=1 and upd_ack=1, the bench SHALL see ticks every 4 cycles, the second and third ticks set overrun, the sweep last 8 cycles, and step_done once.
REQ-033 With NN=1 (NUM_NEURON=4), half_cnt=99, and upd_ack delayed 3 cycles for every neuron, the bench SHALL see PH1 last 4 cycles, the sweep last 28 cycles, and upd_req high exactly 16 cycles.
REQ-034 With NN=1 and spike_in=1 at indices 1 and 3, spk_ready=1: spkid SHALL be 1 then 3, and spk_valid SHALL be high exactly 2 cycles.
REQ-035 With FIFO_DEPTH=4, spk_ready=0, and 6 spikes: drop_cnt SHALL be 2, and the FIFO SHALL then drain 4 IDs in order.
REQ-036 With reset_sim_n pulsed low in PH1 of index 2: the FSM SHALL be IDLE, neuronCounter=0, spk_valid=0, and no step_done.
REQ-037 Without NEURON_SCHED_SPKFIFO_EN and spike_in=1 at index 2, spk_ready=0: spk_valid SHALL be high for 1 cycle with spkid=2.
